// File: rtl/pe_group_pkg.sv
// Shared constants for the PE_Group partial-sum collector.
// Defaults match the PE_Group O_DataOut stream: fp32 words, 4-word blocks, 4-block frames.
// Tag bits sit directly above the data word in each buffered entry.
package pe_group_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int BUFFER_WIDTH      = 2;
    localparam int BUFFER_SIZE       = 4;
    localparam int O_PE_GROUP_SIZE   = 4;
    localparam int O_PE_ADDR_WIDTH   = 2;
    localparam int BLOCK_COUNT       = 4;
    localparam int BLOCK_COUNT_WIDTH = 3;

    // Entry layout: {frame_last, block_last, data}
    localparam int TAG_BLOCK_LAST = DATA_WIDTH;
    localparam int TAG_FRAME_LAST = DATA_WIDTH + 1;

endpackage

// File: rtl/pe_group_fwft_fifo.sv
// First-word-fall-through FIFO: head entry is always visible on rd_data.
// Latency: a push at edge N is visible on rd_data after edge N; no bypass.
// Backpressure: push ignored while full, pop ignored while empty; clr wins over both.
module pe_group_fwft_fifo #(
    parameter int Width    = 34,
    parameter int PtrWidth = 2,
    parameter int Depth    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                push,
    input  logic                pop,
    input  logic [Width-1:0]    wr_data,
    output logic [Width-1:0]    rd_data,
    output logic                full,
    output logic                empty,
    output logic [PtrWidth:0]   count
);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == (PtrWidth+1)'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since Depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrWidth'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PtrWidth+1)'(1);
                2'b01:   count <= count - (PtrWidth+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; empty gating hides stale entries
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pe_group_psum_collector.sv
// Collects PE_Group partial sums, tags block/frame boundaries, re-emits them for writeback.
// Latency: one cycle from input handshake to Out_DataValid (FWFT buffer, no bypass).
// Backpressure: In_DataRdy is registered-state only (not full); Flush drops in-flight words.
module pe_group_psum_collector
    import pe_group_pkg::*;
#(
    parameter int DataWidth       = DATA_WIDTH,
    parameter int BufferWidth     = BUFFER_WIDTH,
    parameter int BufferSize      = BUFFER_SIZE,
    parameter int O_PEGroupSize   = O_PE_GROUP_SIZE,
    parameter int O_PEAddrWidth   = O_PE_ADDR_WIDTH,
    parameter int BlockCount      = BLOCK_COUNT,
    parameter int BlockCountWidth = BLOCK_COUNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       aclr,
    input  logic                       Flush,
    input  logic                       In_DataValid,
    output logic                       In_DataRdy,
    input  logic [DataWidth-1:0]       In_Data,
    output logic                       Out_DataValid,
    input  logic                       Out_DataRdy,
    output logic [DataWidth-1:0]       Out_Data,
    output logic                       Out_BlockLast,
    output logic                       Out_FrameLast,
    output logic                       Frame_Done,
    output logic [O_PEAddrWidth-1:0]   Word_Counter,
    output logic [BlockCountWidth-1:0] Block_Counter,
    output logic [BufferWidth:0]       Fill_Level
);

    localparam int TagBlockLast = DataWidth;
    localparam int TagFrameLast = DataWidth + 1;

    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 block_last_in;
    logic                 frame_last_in;
    logic [DataWidth+1:0] wr_entry;
    logic [DataWidth+1:0] rd_entry;

    assign In_DataRdy    = ~full;
    assign Out_DataValid = ~empty;
    assign push          = In_DataValid & In_DataRdy;
    assign pop           = Out_DataValid & Out_DataRdy;

    assign block_last_in = (Word_Counter == O_PEAddrWidth'(O_PEGroupSize - 1));
    assign frame_last_in = block_last_in &
                           (Block_Counter == BlockCountWidth'(BlockCount - 1));
    assign wr_entry      = {frame_last_in, block_last_in, In_Data};

    pe_group_fwft_fifo #(
        .Width    (DataWidth + 2),
        .PtrWidth (BufferWidth),
        .Depth    (BufferSize)
    ) u_fifo (
        .clk     (clk),
        .rst     (aclr),
        .clr     (Flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .count   (Fill_Level)
    );

    // Head tags are masked while empty so unreset storage never leaks onto the flags
    assign Out_Data      = rd_entry[DataWidth-1:0];
    assign Out_BlockLast = Out_DataValid & rd_entry[TagBlockLast];
    assign Out_FrameLast = Out_DataValid & rd_entry[TagFrameLast];

    // Input-side word/block position, advanced only by accepted words
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            Word_Counter  <= '0;
            Block_Counter <= '0;
        end else if (Flush) begin
            Word_Counter  <= '0;
            Block_Counter <= '0;
        end else if (push) begin
            if (block_last_in) begin
                Word_Counter  <= '0;
                Block_Counter <= frame_last_in ? '0 : Block_Counter + BlockCountWidth'(1);
            end else begin
                Word_Counter  <= Word_Counter + O_PEAddrWidth'(1);
            end
        end
    end

    // One-cycle strobe after the frame's final word leaves the buffer
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)       Frame_Done <= 1'b0;
        else if (Flush) Frame_Done <= 1'b0;
        else            Frame_Done <= pop & Out_FrameLast;
    end

endmodule

// File: tb/tb_pe_group_psum_collector.sv
// Directed self-checking bench for pe_group_psum_collector.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
// Each scenario task does its own comparisons against hand-computed values.
module tb_pe_group_psum_collector;

    logic        clk = 1'b0;
    logic        aclr;
    logic        Flush;
    logic        In_DataValid;
    logic        In_DataRdy;
    logic [31:0] In_Data;
    logic        Out_DataValid;
    logic        Out_DataRdy;
    logic [31:0] Out_Data;
    logic        Out_BlockLast;
    logic        Out_FrameLast;
    logic        Frame_Done;
    logic [1:0]  Word_Counter;
    logic [2:0]  Block_Counter;
    logic [2:0]  Fill_Level;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pe_group_psum_collector dut (
        .clk           (clk),
        .aclr          (aclr),
        .Flush         (Flush),
        .In_DataValid  (In_DataValid),
        .In_DataRdy    (In_DataRdy),
        .In_Data       (In_Data),
        .Out_DataValid (Out_DataValid),
        .Out_DataRdy   (Out_DataRdy),
        .Out_Data      (Out_Data),
        .Out_BlockLast (Out_BlockLast),
        .Out_FrameLast (Out_FrameLast),
        .Frame_Done    (Frame_Done),
        .Word_Counter  (Word_Counter),
        .Block_Counter (Block_Counter),
        .Fill_Level    (Fill_Level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        aclr = 1'b1; Flush = 1'b0; In_DataValid = 1'b1; In_Data = 32'hdead_beef; Out_DataRdy = 1'b0;
        tick();
        n_total++; if (In_DataRdy !== 1'b1) $display("FAIL reset_in_rdy got %b want 1", In_DataRdy); else n_pass++;
        n_total++; if (Out_DataValid !== 1'b0) $display("FAIL reset_out_vld got %b want 0", Out_DataValid); else n_pass++;
        n_total++; if (Fill_Level !== 3'd0) $display("FAIL reset_fill got %0d want 0", Fill_Level); else n_pass++;
        n_total++; if (Frame_Done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", Frame_Done); else n_pass++;
        n_total++; if ({Out_BlockLast, Out_FrameLast} !== 2'b00) $display("FAIL reset_tags got %b want 00", {Out_BlockLast, Out_FrameLast}); else n_pass++;
        n_total++; if ({Word_Counter, Block_Counter} !== 5'd0) $display("FAIL reset_counters got %0d/%0d want 0/0", Word_Counter, Block_Counter); else n_pass++;
        In_DataValid = 1'b0;
        #1 aclr = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        Out_DataRdy = 1'b0; In_DataValid = 1'b1; In_Data = 32'h41a0_0000;
        n_total++; if (Out_DataValid !== 1'b0) $display("FAIL single_no_bypass got %b want 0", Out_DataValid); else n_pass++;
        tick();
        In_DataValid = 1'b0;
        #1;
        n_total++; if (Out_DataValid !== 1'b1) $display("FAIL single_vld got %b want 1", Out_DataValid); else n_pass++;
        n_total++; if (Out_Data !== 32'h41a0_0000) $display("FAIL single_data got %h want 41a00000", Out_Data); else n_pass++;
        n_total++; if (Fill_Level !== 3'd1) $display("FAIL single_fill got %0d want 1", Fill_Level); else n_pass++;
        n_total++; if (Out_BlockLast !== 1'b0) $display("FAIL single_block_last got %b want 0", Out_BlockLast); else n_pass++;
        n_total++; if (Word_Counter !== 2'd1) $display("FAIL single_word_cnt got %0d want 1", Word_Counter); else n_pass++;
        Out_DataRdy = 1'b1;
        tick();
        Out_DataRdy = 1'b0;
        n_total++; if (Fill_Level !== 3'd0) $display("FAIL single_drain_fill got %0d want 0", Fill_Level); else n_pass++;
        do_flush();
    endtask

    task automatic test_full_backpressure();
        logic [31:0] w [5];
        w[0] = 32'h3f80_0000; w[1] = 32'h4000_0000; w[2] = 32'h4040_0000;
        w[3] = 32'h4080_0000; w[4] = 32'h40a0_0000;
        Out_DataRdy = 1'b0; In_DataValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            In_Data = w[i];
            #1;
            n_total++; if (In_DataRdy !== 1'b1) $display("FAIL full_rdy_before_%0d got %b want 1", i, In_DataRdy); else n_pass++;
            tick();
        end
        In_Data = w[4];
        #1;
        n_total++; if (In_DataRdy !== 1'b0) $display("FAIL full_rdy got %b want 0", In_DataRdy); else n_pass++;
        n_total++; if (Fill_Level !== 3'd4) $display("FAIL full_fill got %0d want 4", Fill_Level); else n_pass++;
        tick();
        n_total++; if (Fill_Level !== 3'd4) $display("FAIL full_hold_fill got %0d want 4", Fill_Level); else n_pass++;
        // Full + pop this cycle: the held word must still not be accepted
        Out_DataRdy = 1'b1;
        #1;
        n_total++; if (Out_Data !== w[0]) $display("FAIL full_head0 got %h want %h", Out_Data, w[0]); else n_pass++;
        n_total++; if (In_DataRdy !== 1'b0) $display("FAIL full_pop_no_push got %b want 0", In_DataRdy); else n_pass++;
        tick();
        n_total++; if (Fill_Level !== 3'd3) $display("FAIL full_after_pop_fill got %0d want 3", Fill_Level); else n_pass++;
        n_total++; if (In_DataRdy !== 1'b1) $display("FAIL full_after_pop_rdy got %b want 1", In_DataRdy); else n_pass++;
        n_total++; if (Out_Data !== w[1]) $display("FAIL full_head1 got %h want %h", Out_Data, w[1]); else n_pass++;
        tick();
        In_DataValid = 1'b0;
        n_total++; if (Fill_Level !== 3'd3) $display("FAIL full_swap_fill got %0d want 3", Fill_Level); else n_pass++;
        for (int i = 2; i < 5; i++) begin
            #1;
            n_total++; if (Out_Data !== w[i]) $display("FAIL full_drain_%0d got %h want %h", i, Out_Data, w[i]); else n_pass++;
            n_total++; if (Out_BlockLast !== (i == 3)) $display("FAIL full_block_last_%0d got %b want %b", i, Out_BlockLast, (i == 3)); else n_pass++;
            tick();
        end
        n_total++; if (Out_DataValid !== 1'b0) $display("FAIL full_empty got %b want 0", Out_DataValid); else n_pass++;
        n_total++; if ({Word_Counter, Block_Counter} !== {2'd1, 3'd1}) $display("FAIL full_counters got %0d/%0d want 1/1", Word_Counter, Block_Counter); else n_pass++;
        Out_DataRdy = 1'b0;
        do_flush();
    endtask

    function automatic logic [31:0] frame_word(int i);
        if (i == 5) return 32'h7fc0_0001;       // NaN payload
        if (i == 9) return 32'h0000_0001;       // smallest denormal
        return 32'h3f80_0000 + i;
    endfunction

    task automatic test_frame_stream();
        int done_cnt;
        done_cnt = 0;
        Out_DataRdy = 1'b1;
        for (int c = 0; c < 19; c++) begin
            In_DataValid = (c < 16);
            In_Data = frame_word(c);
            #1;
            if (c < 16) begin
                n_total++; if (In_DataRdy !== 1'b1) $display("FAIL frame_rdy_%0d got %b want 1", c, In_DataRdy); else n_pass++;
            end
            n_total++; if (Out_DataValid !== (c >= 1 && c <= 16)) $display("FAIL frame_vld_%0d got %b want %b", c, Out_DataValid, (c >= 1 && c <= 16)); else n_pass++;
            if (c >= 1 && c <= 16) begin
                n_total++; if (Out_Data !== frame_word(c - 1)) $display("FAIL frame_data_%0d got %h want %h", c - 1, Out_Data, frame_word(c - 1)); else n_pass++;
                n_total++; if (Out_BlockLast !== ((c - 1) % 4 == 3)) $display("FAIL frame_block_last_%0d got %b want %b", c - 1, Out_BlockLast, ((c - 1) % 4 == 3)); else n_pass++;
                n_total++; if (Out_FrameLast !== (c == 16)) $display("FAIL frame_frame_last_%0d got %b want %b", c - 1, Out_FrameLast, (c == 16)); else n_pass++;
            end
            n_total++; if (Frame_Done !== (c == 17)) $display("FAIL frame_done_c%0d got %b want %b", c, Frame_Done, (c == 17)); else n_pass++;
            if (Frame_Done === 1'b1) done_cnt++;
            tick();
        end
        n_total++; if (done_cnt !== 1) $display("FAIL frame_done_count got %0d want 1", done_cnt); else n_pass++;
        n_total++; if ({Word_Counter, Block_Counter} !== 5'd0) $display("FAIL frame_counters got %0d/%0d want 0/0", Word_Counter, Block_Counter); else n_pass++;
        Out_DataRdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        Out_DataRdy = 1'b0; In_DataValid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            In_Data = 32'hc000_0000 + k;
            tick();
        end
        Out_DataRdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            In_Data = 32'hc000_0000 + k + 2;
            #1;
            n_total++; if (Fill_Level !== 3'd2) $display("FAIL b2b_fill_%0d got %0d want 2", k, Fill_Level); else n_pass++;
            n_total++; if (Out_Data !== 32'hc000_0000 + k) $display("FAIL b2b_data_%0d got %h want %h", k, Out_Data, 32'hc000_0000 + k); else n_pass++;
            tick();
        end
        In_DataValid = 1'b0;
        for (int k = 6; k < 8; k++) begin
            #1;
            n_total++; if (Out_Data !== 32'hc000_0000 + k) $display("FAIL b2b_tail_%0d got %h want %h", k, Out_Data, 32'hc000_0000 + k); else n_pass++;
            tick();
        end
        n_total++; if (Fill_Level !== 3'd0) $display("FAIL b2b_end_fill got %0d want 0", Fill_Level); else n_pass++;
        Out_DataRdy = 1'b0;
        do_flush();
    endtask

    task automatic test_flush_mid_frame();
        Out_DataRdy = 1'b0; In_DataValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            In_Data = 32'h5000_0000 + k;
            tick();
        end
        Out_DataRdy = 1'b1;
        for (int k = 3; k < 6; k++) begin
            In_Data = 32'h5000_0000 + k;
            tick();
        end
        Out_DataRdy = 1'b0;
        n_total++; if (Fill_Level !== 3'd3) $display("FAIL flush_pre_fill got %0d want 3", Fill_Level); else n_pass++;
        n_total++; if ({Word_Counter, Block_Counter} !== {2'd2, 3'd1}) $display("FAIL flush_pre_counters got %0d/%0d want 2/1", Word_Counter, Block_Counter); else n_pass++;
        Flush = 1'b1; In_Data = 32'h5fff_ffff;
        #1;
        n_total++; if (In_DataRdy !== 1'b1) $display("FAIL flush_handshake got %b want 1", In_DataRdy); else n_pass++;
        tick();
        Flush = 1'b0; In_DataValid = 1'b0;
        #1;
        n_total++; if (Fill_Level !== 3'd0) $display("FAIL flush_fill got %0d want 0", Fill_Level); else n_pass++;
        n_total++; if ({Word_Counter, Block_Counter} !== 5'd0) $display("FAIL flush_counters got %0d/%0d want 0/0", Word_Counter, Block_Counter); else n_pass++;
        n_total++; if (Out_DataValid !== 1'b0) $display("FAIL flush_vld got %b want 0", Out_DataValid); else n_pass++;
        In_DataValid = 1'b1; In_Data = 32'h4120_0000;
        tick();
        In_DataValid = 1'b0;
        #1;
        n_total++; if (Out_Data !== 32'h4120_0000) $display("FAIL flush_next_data got %h want 41200000", Out_Data); else n_pass++;
        n_total++; if ({Out_BlockLast, Out_FrameLast} !== 2'b00) $display("FAIL flush_next_tags got %b want 00", {Out_BlockLast, Out_FrameLast}); else n_pass++;
        n_total++; if (Word_Counter !== 2'd1) $display("FAIL flush_next_word_cnt got %0d want 1", Word_Counter); else n_pass++;
        // Asynchronous reset mid-stream discards buffer and counts without a clock edge
        #2 aclr = 1'b1;
        #1;
        n_total++; if ({Fill_Level, Word_Counter} !== 5'd0) $display("FAIL areset_mid got %0d/%0d want 0/0", Fill_Level, Word_Counter); else n_pass++;
        aclr = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_backpressure();
        test_frame_stream();
        test_back_to_back();
        test_flush_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pe_group_psum_collector.md
Name: pe_group_psum_collector

Overview:
- Receiving end of the PE_Group O_DataOut valid/rdy stream. It accepts finished partial-sum words, buffers them in a small first-word-fall-through (FWFT) FIFO, and tags each word with block and frame boundaries.
- It re-emits the words on a downstream valid/rdy port with last flags for writeback, and pulses a frame-done strobe.
- It sits between PE_Group and the output writeback/DMA logic.

Parameters:
- DataWidth, 32, width of the IEEE-754 single-precision word; passed through unmodified.
- BufferWidth, 2, FIFO pointer width.
- BufferSize, 4, FIFO depth; must equal 2**BufferWidth.
- O_PEGroupSize, 4, words per block.
- O_PEAddrWidth, 2, word-counter width; must hold O_PEGroupSize-1.
- BlockCount, 4, blocks per frame.
- BlockCountWidth, 3, block-counter width; must hold BlockCount-1.

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- aclr, in, 1, asynchronous active-high reset.
- Flush, in, 1, synchronous clear of the FIFO and all counters.
- In_DataValid, in, 1, upstream word valid; driven by PE_Group O_DataOutValid.
- In_DataRdy, out, 1, collector can accept a word; drives PE_Group O_DataOutRdy.
- In_Data, in, DataWidth, upstream word; driven by PE_Group O_DataOut.
- Out_DataValid, out, 1, downstream word valid.
- Out_DataRdy, in, 1, downstream ready.
- Out_Data, out, DataWidth, word at the FIFO head.
- Out_BlockLast, out, 1, head word is the last word of its block.
- Out_FrameLast, out, 1, head word is the last word of the frame.
- Frame_Done, out, 1, registered one-cycle pulse.
- Word_Counter, out, O_PEAddrWidth, input-side word index within the block.
- Block_Counter, out, BlockCountWidth, input-side block index within the frame.
- Fill_Level, out, BufferWidth+1, number of words currently in the FIFO.

Behaviour:
- Reset (aclr=1, asynchronous): FIFO pointers, fill count, Word_Counter, Block_Counter and Frame_Done all go to 0.
  - Consequently In_DataRdy=1, Out_DataValid=0, Out_BlockLast=0, Out_FrameLast=0 and Fill_Level=0.
  - Out_Data is don't-care while Out_DataValid=0; storage array contents are not reset.
  - A reset during a frame discards all buffered words and any partial count.
- Push condition: In_DataValid & In_DataRdy.
  - In_DataRdy = (Fill_Level != BufferSize).
  - In_DataRdy depends on registered state only; there is no combinational path from Out_DataRdy.
  - When full, a same-cycle pop does not enable a push.
- Pop condition: Out_DataValid & Out_DataRdy.
  - Out_DataValid = (Fill_Level != 0).
  - Out_Data, Out_BlockLast and Out_FrameLast are read combinationally from the entry at the read pointer (FWFT).
- Latency: a word pushed at edge N is visible on Out_Data after edge N, i.e. one cycle of latency.
- Each FIFO entry stores {frame_last, block_last, data}; the tags are computed at push time:
  - block_last = (Word_Counter == O_PEGroupSize-1).
  - frame_last = block_last & (Block_Counter == BlockCount-1).
- Counters advance on push only:
  - Word_Counter wraps to 0 after O_PEGroupSize-1.
  - Block_Counter increments on each wrap and wraps to 0 after BlockCount-1.
- Pointers wrap modulo BufferSize.
- Fill_Level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on a simultaneous push and pop; this is allowed whenever 0 < Fill_Level < BufferSize.
- Empty: a pop is not possible. A push into an empty FIFO makes the word valid on the next cycle; there is no bypass.
- Frame_Done is set for exactly one cycle, in the cycle after a pop of an entry with frame_last=1; otherwise it is 0.
- Flush=1:
  - Next edge clears pointers, Fill_Level, both counters and Frame_Done.
  - Flush takes priority over a push or pop in the same cycle; that word is dropped and upstream sees the handshake as completed.
- Data is never modified; NaN and denormal values are passed through bit-exact.

Decomposition:
- Shared package, pe_group_pkg, holds:
  - Default constants: DataWidth, BufferWidth, BufferSize, O_PEGroupSize, BlockCount.
  - Tag-bit index constants: TAG_BLOCK_LAST = DataWidth, TAG_FRAME_LAST = DataWidth+1.
- One sub-module, pe_group_fwft_fifo: parameterised by width and depth, with push/pop, full/empty and count.
  - The top level adds the counters, tag generation and Frame_Done.

Test Plan:
- Reset: aclr=1 with In_DataValid=1 -> In_DataRdy=1, Out_DataValid=0, Fill_Level=0, Frame_Done=0.
- Single word: push 32'h41a0_0000 with Out_DataRdy=0 -> next cycle Out_DataValid=1, Out_Data=41a0_0000, Fill_Level=1, Out_BlockLast=0.
- Full/backpressure:
  - Stimulus: Out_DataRdy=0; push 5 words 3f80_0000..40a0_0000 with In_DataValid held at 1.
  - Required: In_DataRdy=0 after the 4th push and Fill_Level=4; the 5th word is held upstream.
  - Then raise Out_DataRdy: data drains in order and the 5th word is accepted on the cycle after the first pop.
- Full frame streaming: 16 words with both ready signals held at 1 -> one word per cycle throughput.
  - Out_BlockLast is 1 on words 3, 7, 11 and 15.
  - Out_FrameLast is 1 on word 15 only.
  - Frame_Done pulses once, in the cycle after word 15 pops.
  - Counters end at 0/0.
- Simultaneous push/pop at Fill_Level=2 for 6 cycles -> Fill_Level stays 2 and order is preserved.
- Flush mid-frame:
  - Stimulus: after 6 pushes with 3 buffered, assert Flush together with In_DataValid.
  - Required: Fill_Level=0, Word_Counter=0, Block_Counter=0; the next pushed word has index 0 and its tags are 0.
